// File: rtl/trig_param_bank_pkg.sv
// trig_param_bank_pkg: shared constants, types and helpers for the parameter bank.
//   DW         - parameter word width (fixed at 32)
//   MaxNch     - largest supported channel count
//   ch_idx_t   - channel index wide enough for MaxNch channels
//   trig_bit() - extracts channel i's trigger-bit index from the packed CH_TRIG table
//   Def*       - default model reset values (IEEE-754 single)
package trig_param_bank_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned MaxNch = 32;

  typedef logic [4:0] ch_idx_t;

  localparam logic [DW-1:0] Def80p0   = 32'h42a00000;  // 80.0
  localparam logic [DW-1:0] Def0p2356 = 32'h3e714120;  // 0.2356
  localparam logic [DW-1:0] Def0p0362 = 32'h3d144674;  // 0.0362
  localparam logic [DW-1:0] Def0p0132 = 32'h3c5844d0;  // 0.0132
  localparam logic [DW-1:0] Def1p1    = 32'h3f8ccccd;  // 1.1

  // CH_TRIG is zero-extended to MaxNch byte lanes by the caller.
  function automatic int unsigned trig_bit(input logic [MaxNch*8-1:0] ch_trig,
                                           input int unsigned i);
    return 32'(ch_trig[i*8 +: 8]);
  endfunction

endpackage

// File: rtl/trig_param_slot.sv
// trig_param_slot: one channel of the parameter bank.
//   Macro TRIG_PARAM_BANK_COMMIT_EN selects staged (shadow/active) updates that commit on
//   the step rise; without it a write lands in the active register directly.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   wr, wdata   - write strobe and 32-bit load word
//   rise        - step rising-edge strobe (ignored when staging is disabled)
//   active      - committed parameter value
//   pending     - shadow holds an uncommitted word
//   upd_pulse   - one-cycle pulse when active changes through a write/commit
module trig_param_slot
  import trig_param_bank_pkg::*;
#(
  parameter logic [DW-1:0] RESET_VAL = '0,
  parameter bit            HOLD      = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rise,
  output logic [DW-1:0] active,
  output logic          pending,
  output logic          upd_pulse
);

  logic [DW-1:0] active_q = RESET_VAL;
  logic [DW-1:0] active_d;
  logic          upd_q = 1'b0;
  logic          upd_d;

`ifdef TRIG_PARAM_BANK_COMMIT_EN
  logic [DW-1:0] shadow_q = RESET_VAL;
  logic [DW-1:0] shadow_d;
  logic          pending_q = 1'b0;
  logic          pending_d;

  // Commit reads the old shadow, so a write in the same cycle as a rise stays pending.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    upd_d     = 1'b0;
    if (rise && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      upd_d     = 1'b1;
    end
    if (wr) begin
      shadow_d  = wdata;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      if (!HOLD) begin
        shadow_q <= RESET_VAL;
        active_q <= RESET_VAL;
      end
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
    end
  end

  assign pending = pending_q;
`else
  logic unused_rise;
  assign unused_rise = rise;

  always_comb begin
    active_d = wr ? wdata : active_q;
    upd_d    = wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_q <= 1'b0;
      if (!HOLD) begin
        active_q <= RESET_VAL;
      end
    end else begin
      active_q <= active_d;
      upd_q    <= upd_d;
    end
  end

  assign pending = 1'b0;
`endif

  assign active    = active_q;
  assign upd_pulse = upd_q;

endmodule

// File: rtl/trig_param_bank.sv
// trig_param_bank: bank of NCH 32-bit model parameters loaded from two 16-bit wire-ins on
// per-channel trigger bits, with registered readback.
//   Macro TRIG_PARAM_BANK_COMMIT_EN: stage writes in shadow registers and commit them all
//   atomically on the rising edge of step. Undefined: writes go straight to the active set.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   trig_in           - one-cycle trigger pulses; channel i listens on bit CH_TRIG[i]
//   data_lo, data_hi  - halves of the load word {data_hi, data_lo}
//   step              - simulation-step level signal
//   params            - active values, channel i at [i*DW +: DW]
//   pending, upd_pulse- per-channel staged flag and commit pulse
//   rd_sel, rd_data   - readback select and registered active value (0 if rd_sel >= NCH)
module trig_param_bank
  import trig_param_bank_pkg::*;
#(
  parameter int unsigned       NCH        = 8,
  parameter int unsigned       TRIG_W     = 16,
  parameter logic [NCH*8-1:0]  CH_TRIG    = '0,
  parameter logic [NCH*DW-1:0] RESET_VALS = '0,
  parameter logic [NCH-1:0]    HOLD_MASK  = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [TRIG_W-1:0]                      trig_in,
  input  logic [15:0]                            data_lo,
  input  logic [15:0]                            data_hi,
  input  logic                                   step,
  output logic [NCH*DW-1:0]                      params,
  output logic [NCH-1:0]                         pending,
  output logic [NCH-1:0]                         upd_pulse,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_sel,
  output logic [DW-1:0]                          rd_data
);

  localparam logic [MaxNch*8-1:0] ChTrigExt = (MaxNch*8)'(CH_TRIG);

  logic [DW-1:0] wdata;
  logic          rise;
  logic [DW-1:0] active [NCH];

  assign wdata = {data_hi, data_lo};

`ifdef TRIG_PARAM_BANK_COMMIT_EN
  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign rise = step & ~step_q;
`else
  logic unused_step;
  assign unused_step = step;
  assign rise        = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    localparam int unsigned TrigBit = trig_bit(ChTrigExt, i);

    trig_param_slot #(
      .RESET_VAL (RESET_VALS[i*DW +: DW]),
      .HOLD      (HOLD_MASK[i])
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .wr        (trig_in[TrigBit]),
      .wdata     (wdata),
      .rise      (rise),
      .active    (active[i]),
      .pending   (pending[i]),
      .upd_pulse (upd_pulse[i])
    );

    assign params[i*DW +: DW] = active[i];
  end

  // Readback: out-of-range selects match no channel and return 0.
  ch_idx_t       sel;
  logic [DW-1:0] rd_data_d;
  logic [DW-1:0] rd_data_q;

  assign sel = ch_idx_t'(rd_sel);

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == ch_idx_t'(i)) begin
        rd_data_d = active[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: doc/trig_param_bank.md
# trig_param_bank

Parametrised bank of NCH 32-bit model parameters (gamma drives, damping coefficients, lce, clock divider), loaded from the host's two 16-bit wire-ins on per-channel trigger bits. Replaces the per-parameter latches with a single-clock design. Adds staged (shadow/active) updates that commit atomically on the simulation step, so the spindle and neuron models never see a half-updated parameter set. Sits between the OpalKelly wire-in/trigger endpoints and the model instances in the rack top level.

## Interface
- NCH, 8, number of parameter channels (1..32)
- DW, 32, parameter width; fixed to 32 (IEEE-754 single or raw integer)
- TRIG_W, 16, width of trigger vector
- CH_TRIG, {8'd0,...}, NCH×8 packed; byte i = trigger bit index for channel i (< TRIG_W)
- RESET_VALS, all 0, NCH×DW packed; byte-lane i = reset/power-up value of channel i
- HOLD_MASK, 0, NCH bits; bit i set = channel i keeps its value on reset (clock divider)

- clk  in  1  system clock (clk1 domain); all logic on posedge
- reset  in  1  synchronous, active-high
- trig_in  in  TRIG_W  one-cycle trigger pulses, synchronous to clk
- data_lo  in  16  low half of load word (wire-in 01)
- data_hi  in  16  high half of load word (wire-in 02)
- step  in  1  simulation-step level signal (sim_clk, generated in clk domain)
- params  out  NCH×DW  active values, channel i at [i*DW +: DW]
- pending  out  NCH  shadow written but not yet committed
- upd_pulse  out  NCH  one-cycle pulse when channel's active value is committed
- rd_sel  in  $clog2(NCH) (min 1)  readback channel select
- rd_data  out  DW  registered readback of active value

## Operation
- Load word = {data_hi, data_lo}.
- Channel i is written on any cycle where trig_in[CH_TRIG[i]] = 1. Several channels may be written in the same cycle; all get the same word.
- Shadow path (macro on):
  - a trigger writes shadow[i] and sets pending[i].
  - rise = step & ~step_q, where step_q is a registered copy of step.
  - on a rise cycle, every channel with pending = 1 copies shadow to active, clears pending, and pulses upd_pulse.
- Same-cycle trigger and rise on channel i: the commit uses the old shadow. The new word lands in shadow, pending stays 1, and the word commits on the next rise.
- Repeated triggers to one channel before a rise: last word wins. A single upd_pulse is issued at commit.
- Reset:
  - non-HOLD channels: shadow and active load RESET_VALS[i].
  - HOLD channels: shadow and active unchanged.
  - all channels: pending = 0, upd_pulse = 0, step_q = 0, rd_data = 0.
  - reset mid-pending discards the staged word.
- Power-up initial value of active and shadow = RESET_VALS for all channels, including HOLD channels.
- rd_sel ≥ NCH returns rd_data = 0.

## Timing
- Trigger sampled at edge t:
  - macro off: params updated after edge t (1-cycle latency); upd_pulse high for cycle t+1.
  - macro on: pending visible after edge t.
- step rising between edges k−1 and k: rise is true during cycle k. params and upd_pulse change after edge k. Worst-case latency is one clk cycle after step rises.
- rd_data = active[rd_sel] registered. Latency: 1 cycle from rd_sel, or 1 cycle after params changes.
- reset wins over trigger and rise in the same cycle.

## Configuration
- TRIG_PARAM_BANK_COMMIT_EN defined:
  - shadow registers, step edge detect and pending are built.
  - commit happens only on the step rise.
- Not defined:
  - a trigger writes active directly.
  - pending is tied to 0; step is ignored (no registers).
  - upd_pulse fires the cycle after each write.

## Structure
- Package trig_param_bank_pkg:
  - DW constant (32)
  - ch_idx_t typedef
  - function trig_bit(CH_TRIG, i) returning the byte-lane index
  - the existing default reset constants: 80.0 = 32'h42a00000, 0.2356 = 32'h3e714120, 0.0362 = 32'h3d144674, 0.0132 = 32'h3c5844d0, 1.1 = 32'h3f8ccccd
- Sub-module trig_param_slot:
  - one channel's shadow, active, pending and upd_pulse logic
  - instantiated NCH times in a generate loop
  - top level holds step edge detect and readback mux

## Test plan
- Reset with RESET_VALS ch0 = 32'h42a00000, HOLD_MASK bit7 set, ch7 preloaded 32'd50 → params ch0 = 42a00000 and ch7 = 50 after reset; pending = 0.
- Macro on: data = 32'h3f8ccccd, pulse ch5 trigger, no step → params ch5 unchanged, pending[5] = 1. Then step rises → ch5 = 3f8ccccd one cycle later, upd_pulse[5] one cycle wide, pending[5] = 0.
- Macro on: trigger ch2 in the same cycle as step rise, data = 32'h3e714120 → no commit this step, pending[2] = 1. Commits on the next rise.
- Two triggers to ch3 (32'd1, then 32'd2) before a rise → ch3 = 2, exactly one upd_pulse[3].
- Shared trigger bit for ch0 and ch1, data = 32'hdeadbeef → both update together. Reset asserted while pending → pending cleared and non-HOLD values return to defaults.
- Macro off: trigger ch4 with 32'h3c5844d0 → params ch4 updates after 1 cycle. rd_sel = 4 → rd_data = 3c5844d0 after 1 more cycle. rd_sel = NCH → rd_data = 0.
